tlb_op_ctrl: RTL and testbench

//  Sequences TLBP/TLBR/TLBWI committed in WB against the shared TLB via C0_TLB_Interface.C0 signals.

---
 rtl/tlb_op_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_tlb_op_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_op_ctrl.sv
// Sequences TLBP/TLBR/TLBWI committed in WB against the shared TLB, writes results back to CP0
// and requests a one-cycle refetch flush at op_pc+4 once the op has completed.
module tlb_op_ctrl #(
  parameter int unsigned TLB_ENTRIES = 16,
  parameter int unsigned RD_LAT      = 1,
  parameter int unsigned PROBE_LAT   = 1,
  localparam int unsigned IDX_W      = $clog2(TLB_ENTRIES)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             op_valid,
  input  logic [1:0]       op_type,
  input  logic [31:0]      op_pc,
  output logic             op_ready,
  output logic             busy,
  input  logic             ex_flush,
  input  logic [31:0]      c0_index,
  input  logic [31:0]      c0_entryhi,
  input  logic [31:0]      c0_entrylo0,
  input  logic [31:0]      c0_entrylo1,
  output logic [IDX_W-1:0] tlbrw_index,
  output logic             tlbrw_we,
  output logic [77:0]      tlbrw_wdata,
  input  logic [77:0]      tlbrw_rdata,
  output logic [31:0]      tlbp_entry_hi,
  input  logic [31:0]      tlbp_index,
  output logic             c0_index_we,
  output logic             c0_tlbr_we,
  output logic [31:0]      c0_index_wdata,
  output logic [31:0]      c0_entryhi_wdata,
  output logic [31:0]      c0_entrylo0_wdata,
  output logic [31:0]      c0_entrylo1_wdata,
  output logic             flush_valid,
  output logic [31:0]      flush_pc
);

  localparam int unsigned MAX_LAT = (RD_LAT > PROBE_LAT) ? RD_LAT : PROBE_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [1:0] OpTlbp  = 2'd0;
  localparam logic [1:0] OpTlbr  = 2'd1;
  localparam logic [1:0] OpTlbwi = 2'd2;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StCommit, StFlush} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, wait_lat;
  logic [1:0]        type_q;
  logic [31:0]       pc_q, entryhi_q, probe_q;
  logic [IDX_W-1:0]  index_q;
  tlb_entry_t        wr_q, wr_new, rd_q;
  logic              accept, capture;

  // Fields of the CP0 registers that never reach the TLB.
  logic unused_bits;
  assign unused_bits = ^{c0_index[31:IDX_W], c0_entryhi[12:8], c0_entrylo0[31:26],
                         c0_entrylo1[31:26]};

  // The entry is global only if both halves are marked global.
  always_comb begin
    wr_new      = '0;
    wr_new.vpn2 = c0_entryhi[31:13];
    wr_new.asid = c0_entryhi[7:0];
    wr_new.g    = c0_entrylo0[0] & c0_entrylo1[0];
    wr_new.pfn0 = c0_entrylo0[25:6];
    wr_new.c0   = c0_entrylo0[5:3];
    wr_new.d0   = c0_entrylo0[2];
    wr_new.v0   = c0_entrylo0[1];
    wr_new.pfn1 = c0_entrylo1[25:6];
    wr_new.c1   = c0_entrylo1[5:3];
    wr_new.d1   = c0_entrylo1[2];
    wr_new.v1   = c0_entrylo1[1];
  end

  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    accept            = 1'b0;
    capture           = 1'b0;
    op_ready          = 1'b0;
    busy              = 1'b0;
    tlbrw_index       = '0;
    tlbrw_we          = 1'b0;
    tlbrw_wdata       = '0;
    tlbp_entry_hi     = '0;
    c0_index_we       = 1'b0;
    c0_tlbr_we        = 1'b0;
    c0_index_wdata    = '0;
    c0_entryhi_wdata  = '0;
    c0_entrylo0_wdata = '0;
    c0_entrylo1_wdata = '0;
    flush_valid       = 1'b0;
    flush_pc          = '0;
    wait_lat          = (type_q == OpTlbp) ? CNT_W'(PROBE_LAT) : CNT_W'(RD_LAT);

    // TLB inputs stay stable for the whole ISSUE..WAIT window.
    if (state_q == StIssue || state_q == StWait) begin
      case (type_q)
        OpTlbp:  tlbp_entry_hi = entryhi_q;
        OpTlbr:  tlbrw_index = index_q;
        OpTlbwi: begin
          tlbrw_index = index_q;
          tlbrw_wdata = wr_q;
        end
        default: ;
      endcase
    end

    unique case (state_q)
      StIdle: begin
        op_ready = resetn & ~ex_flush;
        accept   = op_valid & op_ready;
        if (accept) state_d = StIssue;
      end
      StIssue: begin
        busy     = 1'b1;
        tlbrw_we = (type_q == OpTlbwi);
        if (ex_flush) begin
          state_d = StIdle;
        end else if (type_q == OpTlbp || type_q == OpTlbr) begin
          state_d = StWait;
          cnt_d   = CNT_W'(1);
        end else begin
          state_d = StCommit;
        end
      end
      StWait: begin
        busy = 1'b1;
        if (ex_flush) begin
          state_d = StIdle;
        end else if (cnt_q == wait_lat) begin
          capture = 1'b1;
          state_d = StCommit;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StCommit: begin
        busy = 1'b1;
        case (type_q)
          OpTlbp: begin
            c0_index_we    = 1'b1;
            c0_index_wdata = probe_q;
          end
          OpTlbr: begin
            c0_tlbr_we        = 1'b1;
            c0_entryhi_wdata  = {rd_q.vpn2, 5'b0, rd_q.asid};
            c0_entrylo0_wdata = {6'b0, rd_q.pfn0, rd_q.c0, rd_q.d0, rd_q.v0, rd_q.g};
            c0_entrylo1_wdata = {6'b0, rd_q.pfn1, rd_q.c1, rd_q.d1, rd_q.v1, rd_q.g};
          end
          default: ;
        endcase
        state_d = StFlush;
      end
      StFlush: begin
        busy        = 1'b1;
        flush_valid = 1'b1;
        flush_pc    = pc_q + 32'd4;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      type_q    <= '0;
      pc_q      <= '0;
      entryhi_q <= '0;
      index_q   <= '0;
      wr_q      <= '0;
      probe_q   <= '0;
      rd_q      <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        type_q    <= op_type;
        pc_q      <= op_pc;
        entryhi_q <= c0_entryhi;
        index_q   <= c0_index[IDX_W-1:0];
        wr_q      <= wr_new;
      end
      if (capture) begin
        probe_q <= tlbp_index;
        rd_q    <= tlbrw_rdata;
      end
    end
  end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Scoreboard bench for tlb_op_ctrl: directed ops push expected CP0/TLB/flush events, a monitor
// pops and compares them whenever the DUT raises a strobe.
module tb_tlb_op_ctrl;

  localparam int unsigned ENTRIES = 16;
  localparam int RDL = 2;
  localparam int PRL = 1;
  localparam int KW = 0;  // TLB write strobe
  localparam int KP = 1;  // CP0 Index write
  localparam int KR = 2;  // CP0 EntryHi/Lo write
  localparam int KF = 3;  // refetch flush

  // Entry written by the TLBWI vector: vpn2 0x12345, asid 0x5A, G=0.
  localparam logic [77:0] W3 = {19'h12345, 8'h5A, 1'b0, 20'h11111, 3'd3, 1'b1, 1'b1,
                                20'h22222, 3'd2, 1'b0, 1'b1};

  logic        clk = 1'b0;
  logic        resetn;
  logic        op_valid;
  logic [1:0]  op_type;
  logic [31:0] op_pc;
  logic        op_ready, busy, ex_flush;
  logic [31:0] c0_index, c0_entryhi, c0_entrylo0, c0_entrylo1;
  logic [3:0]  tlbrw_index;
  logic        tlbrw_we;
  logic [77:0] tlbrw_wdata, tlbrw_rdata;
  logic [31:0] tlbp_entry_hi, tlbp_index;
  logic        c0_index_we, c0_tlbr_we;
  logic [31:0] c0_index_wdata, c0_entryhi_wdata, c0_entrylo0_wdata, c0_entrylo1_wdata;
  logic        flush_valid;
  logic [31:0] flush_pc;

  tlb_op_ctrl #(.TLB_ENTRIES(ENTRIES), .RD_LAT(RDL), .PROBE_LAT(PRL)) dut (
    .clk(clk), .resetn(resetn), .op_valid(op_valid), .op_type(op_type), .op_pc(op_pc),
    .op_ready(op_ready), .busy(busy), .ex_flush(ex_flush), .c0_index(c0_index),
    .c0_entryhi(c0_entryhi), .c0_entrylo0(c0_entrylo0), .c0_entrylo1(c0_entrylo1),
    .tlbrw_index(tlbrw_index), .tlbrw_we(tlbrw_we), .tlbrw_wdata(tlbrw_wdata),
    .tlbrw_rdata(tlbrw_rdata), .tlbp_entry_hi(tlbp_entry_hi), .tlbp_index(tlbp_index),
    .c0_index_we(c0_index_we), .c0_tlbr_we(c0_tlbr_we), .c0_index_wdata(c0_index_wdata),
    .c0_entryhi_wdata(c0_entryhi_wdata), .c0_entrylo0_wdata(c0_entrylo0_wdata),
    .c0_entrylo1_wdata(c0_entrylo1_wdata), .flush_valid(flush_valid), .flush_pc(flush_pc)
  );

  always #5 clk = ~clk;

  int ecnt = 0;
  int n_checks = 0;
  int n_fail = 0;
  int hs;
  always @(posedge clk) ecnt <= ecnt + 1;

  // TLB model: entry 5 preloaded with vpn2=2, asid=0x12; reads RDL cycles, probes PRL cycles.
  logic [77:0] mem [ENTRIES];
  logic [3:0]  rd_p0, rd_p1;

  function automatic logic [31:0] lookup(input logic [31:0] key);
    logic [31:0] r;
    r = 32'h8000_0000;
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (mem[i][77:59] == key[31:13] && (mem[i][50] || mem[i][58:51] == key[7:0]))
        r = 32'(i);
    return r;
  endfunction

  always @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < ENTRIES; i++) mem[i] <= '0;
      mem[5] <= {19'd2, 8'h12, 51'd0};
    end else if (tlbrw_we) begin
      mem[tlbrw_index] <= tlbrw_wdata;
    end
    rd_p0      <= tlbrw_index;
    rd_p1      <= rd_p0;
    tlbp_index <= lookup(tlbp_entry_hi);
  end
  assign tlbrw_rdata = mem[rd_p1];

  typedef struct {
    int          kind;
    int          at;
    logic [77:0] d0;
    logic [31:0] d1, d2, d3;
  } exp_t;
  exp_t q[$];

  task automatic cmp(input string name, input logic [77:0] act, input logic [77:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, ecnt);
    end
  endtask

  task automatic push(input int kind, input int at, input logic [77:0] d0,
                      input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] d3);
    exp_t e;
    e.kind = kind; e.at = at; e.d0 = d0; e.d1 = d1; e.d2 = d2; e.d3 = d3;
    q.push_back(e);
  endtask

  task automatic got(input int kind, input logic [77:0] d0, input logic [31:0] d1,
                     input logic [31:0] d2, input logic [31:0] d3);
    exp_t e;
    if (q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected strobe: got kind %0d at cycle %0d, expected none", kind, ecnt);
      return;
    end
    e = q.pop_front();
    cmp("event kind", 78'(kind), 78'(e.kind));
    cmp("event cycle", 78'(ecnt), 78'(e.at));
    case (e.kind)
      KW: begin
        cmp("tlbrw_wdata", d0, e.d0);
        cmp("tlbrw_index", 78'(d1), 78'(e.d1));
      end
      KP: cmp("c0_index_wdata", 78'(d1), 78'(e.d1));
      KR: begin
        cmp("c0_entryhi_wdata", 78'(d1), 78'(e.d1));
        cmp("c0_entrylo0_wdata", 78'(d2), 78'(e.d2));
        cmp("c0_entrylo1_wdata", 78'(d3), 78'(e.d3));
      end
      default: cmp("flush_pc", 78'(d1), 78'(e.d1));
    endcase
  endtask

  always @(negedge clk) begin
    if (tlbrw_we) got(KW, tlbrw_wdata, 32'(tlbrw_index), 32'd0, 32'd0);
    if (c0_index_we) got(KP, 78'd0, c0_index_wdata, 32'd0, 32'd0);
    if (c0_tlbr_we) got(KR, 78'd0, c0_entryhi_wdata, c0_entrylo0_wdata, c0_entrylo1_wdata);
    if (flush_valid) got(KF, 78'd0, flush_pc, 32'd0, 32'd0);
  end

  task automatic set_op(input logic [1:0] t, input logic [31:0] pc, input logic [31:0] idx,
                        input logic [31:0] hi, input logic [31:0] lo0, input logic [31:0] lo1);
    op_type = t; op_pc = pc; c0_index = idx; c0_entryhi = hi;
    c0_entrylo0 = lo0; c0_entrylo1 = lo1;
  endtask

  // Returns hs = edge count after the handshake edge (the op's ISSUE cycle).
  task automatic issue(output int hs_o);
    int n;
    op_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!op_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    cmp("op accepted", 78'(op_ready), 78'd1);
    hs_o = ecnt + 1;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    op_type  = 2'd3;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || !op_ready) && n < 30) begin
      @(negedge clk);
      n++;
    end
    cmp("back to idle", 78'({busy, op_ready}), 78'b01);
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0; op_valid = 1'b0; ex_flush = 1'b0;
    set_op(2'd3, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    #3;
    cmp("reset op_ready", 78'(op_ready), 78'd0);
    cmp("reset outputs", 78'({busy, tlbrw_we, c0_index_we, c0_tlbr_we, flush_valid,
                              tlbrw_index, tlbp_entry_hi, flush_pc}), 78'd0);
    @(posedge clk); #2 resetn = 1'b1;
    @(negedge clk);
    cmp("idle op_ready", 78'(op_ready), 78'd1);
    cmp("idle busy", 78'(busy), 78'd0);
    @(posedge clk); #1;

    // TLBP hit and miss
    set_op(2'd0, 32'h0000_1000, 32'd0, 32'h0000_4012, 32'd0, 32'd0);
    issue(hs);
    push(KP, hs + PRL + 1, 78'd0, 32'h0000_0005, 32'd0, 32'd0);
    push(KF, hs + PRL + 2, 78'd0, 32'h0000_1004, 32'd0, 32'd0);
    wait_idle();
    set_op(2'd0, 32'h0000_2000, 32'd0, 32'h0000_8077, 32'd0, 32'd0);
    issue(hs);
    push(KP, hs + PRL + 1, 78'd0, 32'h8000_0000, 32'd0, 32'd0);
    push(KF, hs + PRL + 2, 78'd0, 32'h0000_2004, 32'd0, 32'd0);
    wait_idle();

    // TLBWI to entry 3 with lo0.g=1, lo1.g=0
    set_op(2'd2, 32'h0000_3000, 32'd3, 32'h2468_A05A, 32'h0044_445F, 32'h0088_8892);
    issue(hs);
    push(KW, hs, W3, 32'd3, 32'd0, 32'd0);
    push(KF, hs + 2, 78'd0, 32'h0000_3004, 32'd0, 32'd0);
    wait_idle();

    // TLBR of entry 3; upper Index bits must be ignored
    set_op(2'd1, 32'h0000_3010, 32'hABCD_0003, 32'd0, 32'd0, 32'd0);
    issue(hs);
    push(KR, hs + RDL + 1, 78'd0, 32'h2468_A05A, 32'h0044_445E, 32'h0088_8892);
    push(KF, hs + RDL + 2, 78'd0, 32'h0000_3014, 32'd0, 32'd0);
    wait_idle();

    // no-op, then pc wrap-around
    set_op(2'd3, 32'h0000_4000, 32'd0, 32'd0, 32'd0, 32'd0);
    issue(hs);
    push(KF, hs + 2, 78'd0, 32'h0000_4004, 32'd0, 32'd0);
    wait_idle();
    set_op(2'd3, 32'hFFFF_FFFC, 32'd0, 32'd0, 32'd0, 32'd0);
    issue(hs);
    push(KF, hs + 2, 78'd0, 32'h0000_0000, 32'd0, 32'd0);
    wait_idle();

    // ex_flush during COMMIT is ignored
    set_op(2'd0, 32'h0000_5000, 32'd0, 32'h0000_4012, 32'd0, 32'd0);
    issue(hs);
    push(KP, hs + PRL + 1, 78'd0, 32'h0000_0005, 32'd0, 32'd0);
    push(KF, hs + PRL + 2, 78'd0, 32'h0000_5004, 32'd0, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1 ex_flush = 1'b1;
    @(posedge clk); #1 ex_flush = 1'b0;
    wait_idle();

    // ex_flush during WAIT of TLBR aborts: no CP0 write, no flush
    set_op(2'd1, 32'h0000_6000, 32'd3, 32'd0, 32'd0, 32'd0);
    issue(hs);
    @(posedge clk); #1 ex_flush = 1'b1;
    @(posedge clk); #1 ex_flush = 1'b0;
    @(negedge clk);
    cmp("abort op_ready", 78'(op_ready), 78'd1);
    cmp("abort busy", 78'(busy), 78'd0);
    @(posedge clk); #1;

    // ex_flush with op_valid in IDLE: not accepted
    set_op(2'd0, 32'h0000_7000, 32'd0, 32'h0000_4012, 32'd0, 32'd0);
    op_valid = 1'b1; ex_flush = 1'b1;
    @(negedge clk);
    cmp("ex_flush blocks op_ready", 78'(op_ready), 78'd0);
    @(posedge clk); #1 op_valid = 1'b0; ex_flush = 1'b0;
    @(negedge clk);
    cmp("blocked op not started", 78'(busy), 78'd0);
    @(posedge clk); #1;

    // back-to-back: op_valid held, second op accepted the cycle after FLUSH
    set_op(2'd3, 32'h0000_8000, 32'd0, 32'd0, 32'd0, 32'd0);
    issue(hs);
    op_valid = 1'b1; op_type = 2'd3; op_pc = 32'h0000_9000;
    push(KF, hs + 2, 78'd0, 32'h0000_8004, 32'd0, 32'd0);
    push(KF, hs + 6, 78'd0, 32'h0000_9004, 32'd0, 32'd0);
    @(negedge clk);
    cmp("busy holds op_ready", 78'(op_ready), 78'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp("ready after flush", 78'(op_ready), 78'd1);
    @(posedge clk); #1 op_valid = 1'b0;
    wait_idle();

    // resetn pulsed mid-WAIT of TLBR
    set_op(2'd1, 32'h0000_A000, 32'd3, 32'd0, 32'd0, 32'd0);
    issue(hs);
    @(posedge clk); #2 resetn = 1'b0;
    #1;
    cmp("mid-op reset outputs", 78'({op_ready, busy, tlbrw_we, c0_index_we, c0_tlbr_we,
                                     flush_valid, tlbrw_index, tlbp_entry_hi, flush_pc}), 78'd0);
    @(posedge clk); #2 resetn = 1'b1;
    @(negedge clk);
    cmp("post-reset idle", 78'({busy, op_ready}), 78'b01);
    repeat (5) @(posedge clk);
    #1;
    cmp("scoreboard drained", 78'(q.size()), 78'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
